// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched sequencer.
package counter_sched_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  // Requester indices
  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

  // One-hot grant vector for a requester index
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? (2'b01 << REQ1) : (2'b01 << REQ0);
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Request/grant bundle between the requesters and counter_sched.
interface counter_sched_if
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       grant;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic             done;
  logic             abort;

  // Requester side
  modport master (
    output req, len0, len1,
    input  grant, busy, cnt, done, abort
  );

  // Sequencer side
  modport slave (
    input  req, len0, len1,
    output grant, busy, cnt, done, abort
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sclr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  logic [WIDTH-1:0] r_q;

  // Count register: sync clear wins over enable, hold at saturation
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_q <= '0;
    end else if (sclr) begin
      r_q <= '0;
    end else if (en && (r_q != MaxVal)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/counter_sched.sv
// Round-robin sequencer that lends one saturating counter to two requesters
// for a window of len+1 counting cycles, then pulses done (or abort).
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned NREQ  = 2
) (
  input  logic              clk,
  input  logic              clear_n,
  counter_sched_if.slave    bus
);

  state_e           r_state, w_state_next;
  logic [1:0]       r_grant, w_grant_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_abort, w_abort_next;
  logic [WIDTH-1:0] r_len, w_len_next;
  logic             r_rr, w_rr_next;
  logic             r_winner, w_winner_next;

  logic [NREQ-1:0]  w_req;
  logic             w_pick;
  logic             w_req_win;
  logic             w_sclr;
  logic             w_en;
  logic [WIDTH-1:0] w_cnt;

  assign w_req     = bus.req;
  // Preferred requester wins if asking, otherwise the other one
  assign w_pick    = w_req[r_rr] ? r_rr : ~r_rr;
  assign w_req_win = w_req[r_winner];

  sat_counter #(
    .WIDTH (WIDTH)
  ) u_sat_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .sclr    (w_sclr),
    .en      (w_en),
    .q       (w_cnt)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= IDLE;
      r_grant  <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_len    <= '0;
      r_rr     <= 1'b0;
      r_winner <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_abort  <= w_abort_next;
      r_len    <= w_len_next;
      r_rr     <= w_rr_next;
      r_winner <= w_winner_next;
    end
  end

  // Next-state, arbitration and counter control
  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_abort_next  = 1'b0;
    w_len_next    = r_len;
    w_rr_next     = r_rr;
    w_winner_next = r_winner;
    w_sclr        = 1'b0;
    w_en          = 1'b0;

    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_state_next  = LOAD;
          w_winner_next = w_pick;
          w_grant_next  = req_onehot(w_pick);
          w_len_next    = w_pick ? bus.len1 : bus.len0;
          w_busy_next   = 1'b1;
        end
      end
      LOAD: begin
        w_sclr = 1'b1;
        if (!w_req_win) begin
          w_state_next = FIN;
          w_abort_next = 1'b1;
          w_grant_next = 2'b00;
          w_busy_next  = 1'b0;
        end else begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        // Abort outranks completion; counter freezes on the exit cycle
        if (!w_req_win) begin
          w_state_next = FIN;
          w_abort_next = 1'b1;
          w_grant_next = 2'b00;
          w_busy_next  = 1'b0;
        end else if (w_cnt == r_len) begin
          w_state_next = FIN;
          w_done_next  = 1'b1;
          w_grant_next = 2'b00;
          w_busy_next  = 1'b0;
        end else begin
          w_en = 1'b1;
        end
      end
      FIN: begin
        w_rr_next    = ~r_winner;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;
  assign bus.cnt   = w_cnt;
  assign bus.done  = r_done;
  assign bus.abort = r_abort;

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: stimulus queues expected grant/done/abort
// events and per-busy-cycle counter values; a negedge monitor pops and compares.
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int EvGrant = 0;
  localparam int EvDone  = 1;
  localparam int EvAbort = 2;

  typedef struct {
    int         kind;
    logic [1:0] grant;
    int         cnt;   // -1: don't care
    int         gap;   // cycles since previous event, -1: don't care
  } ev_t;

  logic clk;
  logic clear_n;

  counter_sched_if #(.WIDTH(3)) bus ();

  counter_sched #(
    .WIDTH (3),
    .NREQ  (2)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   mon_kind;
  int   mon_gap;
  int   exp_cnt;
  bit   mon_ok;
  ev_t  mon_e;
  logic [1:0] prev_grant = 2'b00;

  ev_t ev_q[$];
  int  cnt_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Monitor: compare events and busy-cycle counter values against the queues
  always @(negedge clk) begin
    if (clear_n) begin
      mon_kind = -1;
      if (bus.done) mon_kind = EvDone;
      else if (bus.abort) mon_kind = EvAbort;
      else if (bus.grant != 2'b00 && prev_grant == 2'b00) mon_kind = EvGrant;
      if (mon_kind >= 0) begin
        n_checks++;
        mon_gap = cyc - last_cyc;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL event: unexpected kind=%0d grant=%b at cycle %0d",
                   mon_kind, bus.grant, cyc);
        end else begin
          mon_e  = ev_q.pop_front();
          mon_ok = (mon_e.kind == mon_kind) && (bus.grant == mon_e.grant) &&
                   !(bus.done && bus.abort) &&
                   (mon_e.cnt < 0 || int'(bus.cnt) == mon_e.cnt) &&
                   (mon_e.gap < 0 || mon_gap == mon_e.gap);
          if (!mon_ok) begin
            n_fail++;
            $display("FAIL event: got kind=%0d grant=%b cnt=%0d gap=%0d d=%b a=%b, want kind=%0d grant=%b cnt=%0d gap=%0d",
                     mon_kind, bus.grant, bus.cnt, mon_gap, bus.done, bus.abort,
                     mon_e.kind, mon_e.grant, mon_e.cnt, mon_e.gap);
          end
        end
        last_cyc = cyc;
      end
      if (bus.busy) begin
        n_checks++;
        if (cnt_q.size() == 0) begin
          n_fail++;
          $display("FAIL cnt_trace: unexpected busy cycle cnt=%0d", bus.cnt);
        end else begin
          exp_cnt = cnt_q.pop_front();
          if (exp_cnt >= 0 && int'(bus.cnt) != exp_cnt) begin
            n_fail++;
            $display("FAIL cnt_trace: got %0d want %0d", bus.cnt, exp_cnt);
          end
        end
      end
    end
    prev_grant = bus.grant;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [1:0] g, input int c, input int gap);
    ev_t e;
    e.kind  = kind;
    e.grant = g;
    e.cnt   = c;
    e.gap   = gap;
    ev_q.push_back(e);
  endtask

  // LOAD cycle shows a stale count, then 0..last
  task automatic push_trace(input int last);
    cnt_q.push_back(-1);
    for (int i = 0; i <= last; i++) cnt_q.push_back(i);
  endtask

  // which: 0 grant==g, 1 done, 2 abort, 3 busy && cnt==v
  task automatic wait_for(input string name, input int which, input logic [1:0] g,
                          input int v, input int max_cyc);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = (bus.grant == g);
        1: hit = bus.done;
        2: hit = bus.abort;
        default: hit = bus.busy && (int'(bus.cnt) == v);
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s: got no event, want it within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, int'(bus.grant), 0);
    check({tag, "_busy"},  int'(bus.busy),  0);
    check({tag, "_cnt"},   int'(bus.cnt),   0);
    check({tag, "_done"},  int'(bus.done),  0);
    check({tag, "_abort"}, int'(bus.abort), 0);
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n  = 1'b0;
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    clear_n = 1'b1;

    // Single requester, len0=3
    push_ev(EvGrant, 2'b01, -1, -1);
    push_ev(EvDone,  2'b00, -1, 5);
    push_trace(3);
    bus.len0 = 3'd3;
    bus.req  = 2'b01;
    wait_for("t1_done", 1, 2'b00, 0, 20);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // Both request from reset: 0 first, then 1
    do_reset();
    push_ev(EvGrant, 2'b01, -1, -1);
    push_ev(EvDone,  2'b00, -1, 3);
    push_ev(EvGrant, 2'b10, -1, 2);
    push_ev(EvDone,  2'b00, -1, 4);
    push_trace(1);
    push_trace(2);
    bus.len0 = 3'd1;
    bus.len1 = 3'd2;
    bus.req  = 2'b11;
    wait_for("t2_done0", 1, 2'b00, 0, 20);
    wait_for("t2_grant1", 0, 2'b10, 0, 20);
    bus.req = 2'b10;
    wait_for("t2_done1", 1, 2'b00, 0, 20);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // len=0: single RUN cycle
    push_ev(EvGrant, 2'b01, -1, -1);
    push_ev(EvDone,  2'b00, -1, 2);
    push_trace(0);
    bus.len0 = 3'd0;
    bus.req  = 2'b01;
    wait_for("t3_done", 1, 2'b00, 0, 20);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // len=7: full count to saturation, held afterwards
    push_ev(EvGrant, 2'b10, -1, -1);
    push_ev(EvDone,  2'b00, 7, 9);
    push_trace(7);
    bus.len1 = 3'd7;
    bus.req  = 2'b10;
    wait_for("t4_done", 1, 2'b00, 0, 30);
    bus.req  = 2'b00;
    bus.len1 = 3'd2;
    repeat (3) @(negedge clk);
    check("t4_cnt_held", int'(bus.cnt), 7);
    check("t4_busy_idle", int'(bus.busy), 0);

    // Abort at cnt=2, then both request and requester 1 wins
    push_ev(EvGrant, 2'b01, -1, -1);
    push_ev(EvAbort, 2'b00, -1, 4);
    push_ev(EvGrant, 2'b10, -1, 2);
    push_ev(EvDone,  2'b00, -1, 2);
    push_trace(2);
    push_trace(0);
    bus.len0 = 3'd5;
    bus.req  = 2'b01;
    wait_for("t5_cnt2", 3, 2'b00, 2, 20);
    bus.req  = 2'b00;
    wait_for("t5_abort", 2, 2'b00, 0, 5);
    check("t5_abort_no_done", int'(bus.done), 0);
    bus.len1 = 3'd0;
    bus.req  = 2'b11;
    wait_for("t5_grant1", 0, 2'b10, 0, 10);
    bus.req  = 2'b10;
    wait_for("t5_done1", 1, 2'b00, 0, 10);
    bus.req  = 2'b00;
    repeat (2) @(negedge clk);

    // Reset mid-window
    push_ev(EvGrant, 2'b01, -1, -1);
    push_trace(3);
    bus.len0 = 3'd5;
    bus.req  = 2'b01;
    wait_for("t6_cnt3", 3, 2'b00, 3, 20);
    #2;
    clear_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    push_ev(EvGrant, 2'b01, -1, -1);
    push_ev(EvDone,  2'b00, -1, 2);
    push_trace(0);
    bus.len0 = 3'd0;
    bus.len1 = 3'd3;
    bus.req  = 2'b11;
    wait_for("t6_grant0", 0, 2'b01, 0, 10);
    bus.req  = 2'b01;
    wait_for("t6_done", 1, 2'b00, 0, 10);
    bus.req  = 2'b00;
    repeat (4) @(negedge clk);

    check("ev_q_drained", ev_q.size(), 0);
    check("cnt_q_drained", cnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
